// File: rtl/temp_bcd_pkg.sv
// Shared constants and helpers for the fixed-point temperature to BCD converter.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
// Contents: FSM state encoding, nibble width, pow10() and clog2() constant functions.
package temp_bcd_pkg;

   localparam int NIBBLE_W = 4;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PREP = 2'd1;
   localparam logic [1:0] ST_CONV = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // 10^n as a 64-bit constant; n is small (digit counts).
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   // Smallest r with 2^r >= v.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_dabble_iter.sv
// Iterative double-dabble engine: one add-3/shift step per cycle while step=1.
// Latency: VAL_W step cycles after load for a full conversion.
// Backpressure: none; the caller sequences load/step.
// Ports: clk, rst (sync, active-high), load (capture val, clear BCD), val, step, bcd (accumulator).
module bcd_dabble_iter
   import temp_bcd_pkg::*;
#(
   parameter int VAL_W  = 15,
   parameter int DIGITS = 6
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic [VAL_W-1:0]             val,
   input  logic                         step,
   output logic [NIBBLE_W*DIGITS-1:0]   bcd
);

   localparam int BCD_W = NIBBLE_W * DIGITS;

   logic [VAL_W-1:0]       shreg_q, shreg_d;
   logic [BCD_W-1:0]       bcd_q, bcd_d;
   logic [BCD_W-1:0]       adj;
   logic [BCD_W+VAL_W-1:0] shifted;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[i*NIBBLE_W +: NIBBLE_W] >= 4'd5) begin
            adj[i*NIBBLE_W +: NIBBLE_W] = bcd_q[i*NIBBLE_W +: NIBBLE_W] + 4'd3;
         end
      end
      shifted = {adj, shreg_q} << 1;

      bcd_d   = bcd_q;
      shreg_d = shreg_q;
      if (load) begin
         shreg_d = val;
         bcd_d   = '0;
      end else if (step) begin
         bcd_d   = shifted[BCD_W+VAL_W-1:VAL_W];
         shreg_d = shifted[VAL_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
         bcd_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         bcd_q   <= bcd_d;
      end
   end

   assign bcd = bcd_q;

endmodule

// File: rtl/temp_fixed_to_bcd.sv
// Fixed-point temperature sample to rounded, saturating BCD digits with sign/overflow flags.
// Latency: result valid VAL_W+2 cycles after the accept cycle; one sample per VAL_W+3 cycles.
// Backpressure: result held in DONE until out_ready; in_ready is low outside IDLE.
// Ports: clk; rst_n (sync, active-high despite the name); in_valid/in_ready/temp_in sample
// handshake; out_valid/out_ready result handshake; bcd_out digits, neg, ovf flags.
module temp_fixed_to_bcd
   import temp_bcd_pkg::*;
#(
   parameter int DATA_W      = 15,
   parameter int FRAC_W      = 8,
   parameter int INT_DIGITS  = 3,
   parameter int FRAC_DIGITS = 2,
   parameter int SIGNED      = 0
)(
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [DATA_W-1:0]                             temp_in,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [NIBBLE_W*(INT_DIGITS+FRAC_DIGITS)-1:0]  bcd_out,
   output logic                                          neg,
   output logic                                          ovf
);

   localparam int INT_W = DATA_W - FRAC_W;
   localparam int ND    = INT_DIGITS + FRAC_DIGITS;
   localparam int FS_W  = NIBBLE_W * FRAC_DIGITS;
   localparam int VAL_W = INT_W + FS_W;
   localparam int PW    = FRAC_W + FS_W;
   localparam int ACC_W = NIBBLE_W * (ND + 1);
   localparam int CNT_W = (clog2(VAL_W) < 1) ? 1 : clog2(VAL_W);

   localparam logic [63:0]      MAXV       = pow10(ND) - 64'd1;
   localparam logic [PW-1:0]    FRAC_SCALE = PW'(pow10(FRAC_DIGITS));
   localparam logic [PW-1:0]    HALF_LSB   = PW'(64'd1 << (FRAC_W - 1));
   localparam logic [VAL_W-1:0] INT_SCALE  = VAL_W'(pow10(FRAC_DIGITS));
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(VAL_W - 1);

   state_t                  state_q, state_d;
   logic [DATA_W-1:0]       sample_q, sample_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    neg_r_q, neg_r_d;
   logic                    ovf_r_q, ovf_r_d;
   logic [NIBBLE_W*ND-1:0]  bcd_hold_q, bcd_hold_d;
   logic                    neg_hold_q, neg_hold_d;
   logic                    ovf_hold_q, ovf_hold_d;

   logic                    sample_neg;
   logic [DATA_W-1:0]       mag;
   logic [FS_W-1:0]         frac_dec;
   logic [VAL_W-1:0]        val;
   logic                    val_ovf;
   logic [ACC_W-1:0]        acc;
   logic                    ovf_flag;
   logic [NIBBLE_W*ND-1:0]  bcd_fin;

   // Magnitude is taken on DATA_W bits and read unsigned, so the most-negative
   // code maps to 2^(DATA_W-1) exactly. Fraction rounds half up to FRAC_DIGITS.
   always_comb begin
      sample_neg = (SIGNED != 0) && sample_q[DATA_W-1];
      mag        = sample_neg ? -sample_q : sample_q;
      frac_dec   = FS_W'((PW'(mag[FRAC_W-1:0]) * FRAC_SCALE + HALF_LSB) >> FRAC_W);
      val        = VAL_W'(mag[DATA_W-1:FRAC_W]) * INT_SCALE + VAL_W'(frac_dec);
      val_ovf    = 64'(val) > MAXV;
   end

   bcd_dabble_iter #(
      .VAL_W  (VAL_W),
      .DIGITS (ND + 1)
   ) u_dabble (
      .clk  (clk),
      .rst  (rst_n),
      .load (state_q == ST_PREP),
      .val  (val),
      .step (state_q == ST_CONV),
      .bcd  (acc)
   );

   // The spare top digit is non-zero exactly when the value exceeds MAXV, so it
   // agrees with the PREP compare; both feed the saturation select.
   assign ovf_flag = ovf_r_q | (|acc[ACC_W-1 -: NIBBLE_W]);
   assign bcd_fin  = ovf_flag ? {ND{4'h9}} : acc[NIBBLE_W*ND-1:0];

   always_comb begin
      state_d    = state_q;
      sample_d   = sample_q;
      cnt_d      = cnt_q;
      neg_r_d    = neg_r_q;
      ovf_r_d    = ovf_r_q;
      bcd_hold_d = bcd_hold_q;
      neg_hold_d = neg_hold_q;
      ovf_hold_d = ovf_hold_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sample_d = temp_in;
               state_d  = ST_PREP;
            end
         end
         ST_PREP: begin
            neg_r_d = sample_neg;
            ovf_r_d = val_ovf;
            cnt_d   = '0;
            state_d = ST_CONV;
         end
         ST_CONV: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Snapshot so the outputs hold after the handshake while the
            // accumulator is reused by the next conversion.
            bcd_hold_d = bcd_fin;
            neg_hold_d = neg_r_q;
            ovf_hold_d = ovf_flag;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q    <= ST_IDLE;
         sample_q   <= '0;
         cnt_q      <= '0;
         neg_r_q    <= 1'b0;
         ovf_r_q    <= 1'b0;
         bcd_hold_q <= '0;
         neg_hold_q <= 1'b0;
         ovf_hold_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sample_q   <= sample_d;
         cnt_q      <= cnt_d;
         neg_r_q    <= neg_r_d;
         ovf_r_q    <= ovf_r_d;
         bcd_hold_q <= bcd_hold_d;
         neg_hold_q <= neg_hold_d;
         ovf_hold_q <= ovf_hold_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE) && !rst_n;
   assign out_valid = (state_q == ST_DONE);
   assign bcd_out   = out_valid ? bcd_fin  : bcd_hold_q;
   assign neg       = out_valid ? neg_r_q  : neg_hold_q;
   assign ovf       = out_valid ? ovf_flag : ovf_hold_q;

endmodule

// File: tb/tb_temp_fixed_to_bcd.sv
module tb_temp_fixed_to_bcd;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, out_ready;
   logic [14:0] temp_in;

   logic        rdy_a, vld_a, neg_a, ovf_a;
   logic [19:0] bcd_a;
   logic        rdy_s, vld_s, neg_s, ovf_s;
   logic [19:0] bcd_s;
   logic        rdy_2, vld_2, neg_2, ovf_2;
   logic [15:0] bcd_2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   temp_fixed_to_bcd dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .temp_in(temp_in),
      .out_valid(vld_a), .out_ready(out_ready), .bcd_out(bcd_a), .neg(neg_a), .ovf(ovf_a));

   temp_fixed_to_bcd #(.SIGNED(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .temp_in(temp_in),
      .out_valid(vld_s), .out_ready(out_ready), .bcd_out(bcd_s), .neg(neg_s), .ovf(ovf_s));

   temp_fixed_to_bcd #(.INT_DIGITS(2)) dut_2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_2), .temp_in(temp_in),
      .out_valid(vld_2), .out_ready(out_ready), .bcd_out(bcd_2), .neg(neg_2), .ovf(ovf_2));

   // Reference: interpret the sample as a real number of 1/256 units, scale the whole
   // thing to hundredths with round-half-up, then split into decimal digits.
   function automatic void model(input logic [14:0] t, input bit sgn, input int nd,
                                 output logic [19:0] bcd, output logic ng, output logic ov);
      int sv, mag, v, p;
      sv  = (sgn && t[14]) ? int'(t) - 32768 : int'(t);
      ng  = (sv < 0);
      mag = ng ? -sv : sv;
      v   = (mag * 100 + 128) / 256;
      ov  = (v > 10**nd - 1);
      bcd = '0;
      p   = 1;
      for (int i = 0; i < nd; i++) begin
         bcd[4*i +: 4] = ov ? 4'd9 : 4'((v / p) % 10);
         p = p * 10;
      end
   endfunction

   // Drives one sample, returns cycles from the accept cycle (counted as 1) to out_valid.
   task automatic send_and_wait(input logic [14:0] t, output int lat);
      int guard;
      @(negedge clk);
      in_valid = 1'b1;
      temp_in  = t;
      guard    = 0;
      while (rdy_a !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      temp_in  = 15'($urandom);
      lat      = 1;
      while (vld_a !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (vld_a !== 1'b1) lat = -1;
   endtask

   task automatic release_out(input int hold);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; temp_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rdy_a, rdy_s, rdy_2} !== 3'b000) begin
         errors++; $display("FAIL reset_in_ready got %b exp 000", {rdy_a, rdy_s, rdy_2});
      end
      checks++;
      if ({vld_a, vld_s, vld_2} !== 3'b000) begin
         errors++; $display("FAIL reset_out_valid got %b exp 000", {vld_a, vld_s, vld_2});
      end
      checks++;
      if ({bcd_a, bcd_s, bcd_2} !== 56'h0) begin
         errors++; $display("FAIL reset_bcd got %h %h %h exp 0", bcd_a, bcd_s, bcd_2);
      end
      checks++;
      if ({neg_a, ovf_a, neg_s, ovf_s, neg_2, ovf_2} !== 6'b0) begin
         errors++; $display("FAIL reset_flags got %b exp 000000", {neg_a, ovf_a, neg_s, ovf_s, neg_2, ovf_2});
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rdy_a, rdy_s, rdy_2} !== 3'b111) begin
         errors++; $display("FAIL post_reset_in_ready got %b exp 111", {rdy_a, rdy_s, rdy_2});
      end
   endtask

   task automatic test_directed();
      logic [14:0] d_t [7];
      logic [19:0] d_a [7];
      logic [19:0] d_s [7];
      logic        d_ns[7];
      logic [15:0] d_2 [7];
      logic        d_o2[7];
      int lat;
      d_t  = '{15'h2540, 15'h24FF, 15'h7FFF, 15'h7F00, 15'h4000, 15'h7F80, 15'h0020};
      d_a  = '{20'h03725, 20'h03700, 20'h12800, 20'h12700, 20'h06400, 20'h12750, 20'h00013};
      d_s  = '{20'h03725, 20'h03700, 20'h00000, 20'h00100, 20'h06400, 20'h00050, 20'h00013};
      d_ns = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      d_2  = '{16'h3725, 16'h3700, 16'h9999, 16'h9999, 16'h6400, 16'h9999, 16'h0013};
      d_o2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         send_and_wait(d_t[i], lat);
         checks++;
         if (lat !== 17) begin
            errors++; $display("FAIL dir_latency t=%h got %0d exp 17", d_t[i], lat);
         end
         checks++;
         if ({bcd_a, neg_a, ovf_a} !== {d_a[i], 2'b00}) begin
            errors++; $display("FAIL dir_unsigned t=%h got %h/%b/%b exp %h/0/0", d_t[i], bcd_a, neg_a, ovf_a, d_a[i]);
         end
         checks++;
         if ({vld_s, bcd_s, neg_s, ovf_s} !== {1'b1, d_s[i], d_ns[i], 1'b0}) begin
            errors++; $display("FAIL dir_signed t=%h got %b/%h/%b/%b exp 1/%h/%b/0", d_t[i], vld_s, bcd_s, neg_s, ovf_s, d_s[i], d_ns[i]);
         end
         checks++;
         if ({vld_2, bcd_2, neg_2, ovf_2} !== {1'b1, d_2[i], 1'b0, d_o2[i]}) begin
            errors++; $display("FAIL dir_int2 t=%h got %b/%h/%b/%b exp 1/%h/0/%b", d_t[i], vld_2, bcd_2, neg_2, ovf_2, d_2[i], d_o2[i]);
         end
         release_out(i % 3);
      end
   endtask

   task automatic test_random();
      logic [14:0] edges [4];
      logic [14:0] t;
      logic [19:0] e;
      logic        en, eo;
      int lat;
      edges = '{15'h0000, 15'h4000, 15'h3FFF, 15'h7FFF};
      for (int i = 0; i < 40; i++) begin
         t = (i < 4) ? edges[i] : 15'($urandom);
         send_and_wait(t, lat);
         checks++;
         if (lat !== 17) begin
            errors++; $display("FAIL rand_latency t=%h got %0d exp 17", t, lat);
         end
         model(t, 1'b0, 5, e, en, eo);
         checks++;
         if ({bcd_a, neg_a, ovf_a} !== {e, en, eo}) begin
            errors++; $display("FAIL rand_unsigned t=%h got %h/%b/%b exp %h/%b/%b", t, bcd_a, neg_a, ovf_a, e, en, eo);
         end
         model(t, 1'b1, 5, e, en, eo);
         checks++;
         if ({bcd_s, neg_s, ovf_s} !== {e, en, eo}) begin
            errors++; $display("FAIL rand_signed t=%h got %h/%b/%b exp %h/%b/%b", t, bcd_s, neg_s, ovf_s, e, en, eo);
         end
         model(t, 1'b0, 4, e, en, eo);
         checks++;
         if ({bcd_2, neg_2, ovf_2} !== {e[15:0], en, eo}) begin
            errors++; $display("FAIL rand_int2 t=%h got %h/%b/%b exp %h/%b/%b", t, bcd_2, neg_2, ovf_2, e[15:0], en, eo);
         end
         release_out($urandom_range(0, 3));
      end
   endtask

   task automatic test_backpressure();
      int lat;
      send_and_wait(15'h2540, lat);
      checks++;
      if (lat !== 17) begin
         errors++; $display("FAIL bp_latency got %0d exp 17", lat);
      end
      @(negedge clk);
      in_valid = 1'b1;
      temp_in  = 15'h24FF;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({vld_a, bcd_a, neg_a, ovf_a} !== {1'b1, 20'h03725, 2'b00}) begin
            errors++; $display("FAIL bp_hold cyc=%0d got %b/%h/%b/%b exp 1/03725/0/0", i, vld_a, bcd_a, neg_a, ovf_a);
         end
         checks++;
         if (rdy_a !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready cyc=%0d got %b exp 0", i, rdy_a);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if ({vld_a, rdy_a, bcd_a} !== {2'b01, 20'h03725}) begin
         errors++; $display("FAIL bp_release got vld=%b rdy=%b bcd=%h exp 0/1/03725", vld_a, rdy_a, bcd_a);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (rdy_a !== 1'b0) begin
         errors++; $display("FAIL bp_second_accept got rdy=%b exp 0", rdy_a);
      end
      lat = 1;
      while (vld_a !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat !== 17 || bcd_a !== 20'h03700) begin
         errors++; $display("FAIL bp_second_result got lat=%0d bcd=%h exp 17/03700", lat, bcd_a);
      end
      release_out(0);
   endtask

   task automatic test_back_to_back();
      logic [14:0] vals [4];
      int acc_cyc [4];
      logic [19:0] e;
      logic        en, eo;
      int guard, n;
      vals = '{15'($urandom), 15'($urandom), 15'($urandom), 15'h4000};
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         guard = 0;
         while (rdy_a !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         temp_in = vals[k];
         @(posedge clk);
         #1;
         acc_cyc[k] = cyc;
         n = 0;
         while (vld_a !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
         model(vals[k], 1'b0, 5, e, en, eo);
         checks++;
         if ({vld_a, bcd_a, ovf_a} !== {1'b1, e, eo}) begin
            errors++; $display("FAIL b2b_result k=%0d t=%h got %b/%h/%b exp 1/%h/%b", k, vals[k], vld_a, bcd_a, ovf_a, e, eo);
         end
         if (k > 0) begin
            checks++;
            if (acc_cyc[k] - acc_cyc[k-1] !== 18) begin
               errors++; $display("FAIL b2b_period k=%0d got %0d exp 18", k, acc_cyc[k] - acc_cyc[k-1]);
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midconv();
      int guard, lat;
      @(negedge clk);
      in_valid = 1'b1;
      temp_in  = 15'h7F00;
      guard = 0;
      while (rdy_a !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({vld_a, vld_s, vld_2, rdy_a} !== 4'b0000) begin
         errors++; $display("FAIL midrst_handshake got vld=%b%b%b rdy=%b exp 000/0", vld_a, vld_s, vld_2, rdy_a);
      end
      checks++;
      if ({bcd_a, bcd_s, bcd_2} !== 56'h0) begin
         errors++; $display("FAIL midrst_bcd got %h %h %h exp 0", bcd_a, bcd_s, bcd_2);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({vld_a, rdy_a} !== 2'b00) begin
         errors++; $display("FAIL midrst_held got vld=%b rdy=%b exp 0/0", vld_a, rdy_a);
      end
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      send_and_wait(15'h2540, lat);
      checks++;
      if (lat !== 17 || {bcd_a, neg_a, ovf_a} !== {20'h03725, 2'b00}) begin
         errors++; $display("FAIL midrst_after got lat=%0d bcd=%h exp 17/03725", lat, bcd_a);
      end
      release_out(0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_midconv();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/temp_fixed_to_bcd.md
Name: temp_fixed_to_bcd

Overview:
- Parametrised successor to the body-temperature display converter.
- Takes one fixed-point temperature sample (integer + binary fraction, optionally two's-complement) through a valid/ready handshake.
- Produces rounded decimal integer and fraction BCD digits plus sign and overflow flags, using an iterative double-dabble engine.
- Sits between the temperature sensor interface and the seven-segment/LCD display drivers.

Parameters:
- DATA_W, 15: input sample width.
- FRAC_W, 8: number of binary fraction bits (LSBs of the sample).
- INT_DIGITS, 3: decimal integer digits output.
- FRAC_DIGITS, 2: decimal fraction digits output; must be >= 1.
- SIGNED, 0: 1 = input is two's complement; 0 = unsigned.
- Derived localparams:
  - INT_W = DATA_W-FRAC_W.
  - ND = INT_DIGITS+FRAC_DIGITS.
  - VAL_W = INT_W+4*FRAC_DIGITS.
  - MAXV = 10^ND-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-high (rst_n=1 resets on the clk edge).
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- temp_in  in  DATA_W  fixed-point temperature sample.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- bcd_out  out  4*ND  BCD digits; nibble 0 = least-significant fraction digit, nibble ND-1 = most-significant integer digit.
- neg  out  1  sample was negative (SIGNED=1 only, else 0).
- ovf  out  1  value exceeded MAXV; bcd_out saturated to all 9s.

Behaviour:
- Reset values:
  - in_ready=0 during reset, 1 in the first IDLE cycle after reset.
  - out_valid=0, bcd_out=0, neg=0, ovf=0.
  - State goes to IDLE.
  - Reset mid-conversion discards the sample without producing an output.
- States: IDLE -> PREP -> CONV -> DONE -> IDLE.
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready, capture temp_in and go to PREP.
  - PREP (1 cycle):
    - mag = SIGNED && temp_in[MSB] ? -temp_in : temp_in, computed on DATA_W bits, treated unsigned, so the most-negative input converts exactly.
    - neg_r = SIGNED && temp_in[MSB].
    - ip = mag[DATA_W-1:FRAC_W].
    - fs = (mag[FRAC_W-1:0]*10^FRAC_DIGITS + 2^(FRAC_W-1)) >> FRAC_W, i.e. round half up.
    - V = ip*10^FRAC_DIGITS + fs, on VAL_W bits. fs may equal 10^FRAC_DIGITS; the sum carries into the integer part naturally, with no special case.
    - ovf_r = (V > MAXV).
    - Load the shift register with V and clear the BCD accumulator.
  - CONV (exactly VAL_W cycles):
    - Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, shreg} left by 1.
    - A counter runs 0..VAL_W-1 and exits on the last cycle.
    - The accumulator is 4*ND+4 bits wide so it never truncates; excess digits feed only the overflow path.
  - DONE:
    - out_valid=1.
    - bcd_out = ovf_r ? all-9s : low 4*ND accumulator bits.
    - neg = neg_r, ovf = ovf_r.
    - Outputs are stable while out_valid=1 && out_ready=0.
    - On out_ready, go to IDLE next cycle; out_valid deasserts.
    - bcd_out/neg/ovf hold their last value until the next DONE.
- Latency: from the accept edge to out_valid high is VAL_W+2 cycles, constant regardless of value or overflow. With defaults this is 17 cycles.
- Throughput: one sample per VAL_W+3 cycles when out_ready is tied high.
- in_valid is ignored while in_ready=0.
- No accept occurs in the same cycle as an output handshake.
- out_ready asserted outside DONE has no effect.
- Negative zero after rounding (e.g. -0.001 rounded to 0.00) reports neg=1. The display layer suppresses the sign.

Decomposition:
- Package temp_bcd_pkg:
  - State encoding (IDLE/PREP/CONV/DONE).
  - NIBBLE_W=4.
  - pow10(n) constant function.
  - clog2 helper.
- Sub-module bcd_dabble_iter:
  - Parametrised by VAL_W and digit count.
  - Ports: load, val, step, bcd.
  - Performs the add-3/shift engine; the top level owns the FSM, rounding, sign and saturation.

Test Plan:
- Defaults, temp_in=15'h2540 (37 + 64/256) -> 17 cycles later: bcd_out=20'h03725 (037.25), neg=0, ovf=0.
- Defaults, temp_in=15'h24FF (36.996) -> rounds up with carry: bcd_out=20'h03700, ovf=0.
- Defaults, temp_in=15'h7FFF -> bcd_out=20'h12800 (128.00). Same input with INT_DIGITS=2 -> bcd_out=16'h9999, ovf=1.
- SIGNED=1: temp_in=15'h7F00 -> bcd_out=20'h00100, neg=1. temp_in=15'h4000 -> bcd_out=20'h06400, neg=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Outputs must stay stable, in_ready=0, and a second in_valid is ignored. After release, a new sample is accepted in the next IDLE cycle.
- Reset: assert rst_n=1 on the 5th CONV cycle -> next cycle out_valid=0, bcd_out=0, in_ready=0 until reset is released. The following sample 15'h2540 converts correctly.
